// File: rtl/fetch_regfile_stage.sv
// -----------------------------------------------------------------------------
// fetch_regfile_stage
//
// Front end of the first pipelined core. It holds the PC, chooses the next PC
// (PC+4 or a redirect target), fetches from a loadable instruction memory, and
// latches the fetched word into an IF/ID register that supports stall and
// flush. From the IF/ID instruction it also supplies the two register-file
// read operands. Both operands bypass the value being written back in the
// same cycle.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   PCSrc, PCTarget          redirect request and target (wins over stall)
//   stall, flush             hold PC + IF/ID / invalidate IF/ID (flush wins)
//   imem_we/waddr/wdata      instruction memory load port (word addressed)
//   RegWrite/WriteReg/Result writeback port into the register file
//   PC, PCPlus4              current fetch PC and its successor
//   Instr, PC_d, valid_d     IF/ID instruction, PC and valid
//   SrcA, WriteData          register values for Instr[25:21] / Instr[20:16]
//   fetch_count              saturating count of valid words captured in IF/ID
//
// Handshake: there is no valid/ready pair on this block. stall is the only
// back-pressure. While stall=1 (and no redirect or flush) the PC and the
// IF/ID contents are guaranteed stable, so the consumer may take its time.
// -----------------------------------------------------------------------------
module fetch_regfile_stage #(
    parameter int                DATA_W     = 32,
    parameter int                NREGS      = 32,
    parameter int                IMEM_DEPTH = 64,
    parameter logic [DATA_W-1:0] RESET_PC   = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          PCSrc,
    input  logic [DATA_W-1:0]             PCTarget,
    input  logic                          stall,
    input  logic                          flush,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [DATA_W-1:0]             imem_wdata,
    input  logic                          RegWrite,
    input  logic [4:0]                    WriteReg,
    input  logic [DATA_W-1:0]             Result,
    output logic [DATA_W-1:0]             PC,
    output logic [DATA_W-1:0]             PCPlus4,
    output logic [DATA_W-1:0]             Instr,
    output logic [DATA_W-1:0]             PC_d,
    output logic                          valid_d,
    output logic [DATA_W-1:0]             SrcA,
    output logic [DATA_W-1:0]             WriteData,
    output logic [15:0]                   fetch_count
);

    localparam int AW = $clog2(IMEM_DEPTH);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] pc_q,          pc_d;
    logic [DATA_W-1:0] instr_q,       instr_d;
    logic [DATA_W-1:0] ifid_pc_q,     ifid_pc_d;
    logic              valid_q,       valid_d_n;
    logic [15:0]       fetch_count_q, fetch_count_d;

    logic [DATA_W-1:0] imem_q [IMEM_DEPTH];
    logic [DATA_W-1:0] regs_q [NREGS];

    // -------------------------------------------------------------------------
    // Fetch
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] pc_plus4;
    logic [AW-1:0]     fetch_idx;
    logic              fetch_in_range;
    logic [DATA_W-1:0] fetched_word;
    logic              ifid_load;

    assign pc_plus4  = pc_q + DATA_W'(4);
    assign fetch_idx = pc_q[2 +: AW];

    // Any PC bit above the memory window means the address is past the end.
    // Such an address returns a NOP; it does not wrap back into the memory.
    assign fetch_in_range = (pc_q[DATA_W-1:AW+2] == '0);
    assign fetched_word   = fetch_in_range ? imem_q[fetch_idx] : '0;

    // IF/ID takes a fresh word only when neither flush nor stall applies.
    assign ifid_load = !flush && !stall;

    always_comb begin
        pc_d          = pc_q;
        instr_d       = instr_q;
        ifid_pc_d     = ifid_pc_q;
        valid_d_n     = valid_q;
        fetch_count_d = fetch_count_q;

        // A redirect takes effect even while stalled.
        if (PCSrc) begin
            pc_d = PCTarget;
        end else if (!stall) begin
            pc_d = pc_plus4;
        end

        if (flush) begin
            instr_d   = '0;
            ifid_pc_d = '0;
            valid_d_n = 1'b0;
        end else if (ifid_load) begin
            instr_d   = fetched_word;
            ifid_pc_d = pc_q;
            valid_d_n = 1'b1;
            if (fetch_count_q != 16'hFFFF) begin
                fetch_count_d = fetch_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            ifid_pc_q     <= '0;
            valid_q       <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            ifid_pc_q     <= ifid_pc_d;
            valid_q       <= valid_d_n;
            fetch_count_q <= fetch_count_d;
        end
    end

    // The instruction memory is deliberately left out of reset, so a program
    // loaded before reset survives it. A fetch in the same cycle as a write
    // sees the old word, because the read is combinational off the array.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem_q[imem_waddr] <= imem_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Register file
    // -------------------------------------------------------------------------
    logic [4:0] rs_field;
    logic [4:0] rt_field;

    assign rs_field = instr_q[25:21];
    assign rt_field = instr_q[20:16];

    // The loops run only over 1..NREGS-1. A field of 0, or a field at or above
    // NREGS, matches no entry and reads 0. The writeback bypass sits inside
    // the same loop, so it can never fire for r0 or for an out-of-range field.
    always_comb begin
        SrcA      = '0;
        WriteData = '0;
        for (int r = 1; r < NREGS; r++) begin
            if (rs_field == 5'(r)) begin
                SrcA = (RegWrite && (WriteReg == rs_field)) ? Result : regs_q[r];
            end
            if (rt_field == 5'(r)) begin
                WriteData = (RegWrite && (WriteReg == rt_field)) ? Result : regs_q[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else if (RegWrite) begin
            for (int r = 1; r < NREGS; r++) begin
                if (WriteReg == 5'(r)) begin
                    regs_q[r] <= Result;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign PC          = pc_q;
    assign PCPlus4     = pc_plus4;
    assign Instr       = instr_q;
    assign PC_d        = ifid_pc_q;
    assign valid_d     = valid_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_regfile_stage.sv
module tb_fetch_regfile_stage;

    localparam int DATA_W     = 32;
    localparam int NREGS      = 16;
    localparam int IMEM_DEPTH = 64;

    logic              clk;
    logic              rst;
    logic              PCSrc;
    logic [31:0]       PCTarget;
    logic              stall;
    logic              flush;
    logic              imem_we;
    logic [5:0]        imem_waddr;
    logic [31:0]       imem_wdata;
    logic              RegWrite;
    logic [4:0]        WriteReg;
    logic [31:0]       Result;
    logic [31:0]       PC;
    logic [31:0]       PCPlus4;
    logic [31:0]       Instr;
    logic [31:0]       PC_d;
    logic              valid_d;
    logic [31:0]       SrcA;
    logic [31:0]       WriteData;
    logic [15:0]       fetch_count;

    int tests_run;
    int tests_failed;

    // Instruction with rs=5 (bits 25:21) and rt=20 (bits 20:16).
    localparam logic [31:0] INSTR_R5_R20 = 32'h00B4_0000;

    fetch_regfile_stage #(
        .DATA_W(DATA_W), .NREGS(NREGS), .IMEM_DEPTH(IMEM_DEPTH), .RESET_PC(32'h0)
    ) dut (
        .clk(clk), .rst(rst), .PCSrc(PCSrc), .PCTarget(PCTarget),
        .stall(stall), .flush(flush),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .Result(Result),
        .PC(PC), .PCPlus4(PCPlus4), .Instr(Instr), .PC_d(PC_d),
        .valid_d(valid_d), .SrcA(SrcA), .WriteData(WriteData),
        .fetch_count(fetch_count)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge; outputs settle and inputs change 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; PCSrc = 1'b0; PCTarget = '0; stall = 1'b0; flush = 1'b0;
        imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
        RegWrite = 1'b0; WriteReg = '0; Result = '0;
        tick(); tick();
        rst = 1'b0;
        tests_run++; if (PC !== 32'h0) begin tests_failed++; $display("FAIL reset_pc got=%h exp=%h", PC, 32'h0); end
        tests_run++; if (PCPlus4 !== 32'h4) begin tests_failed++; $display("FAIL reset_pcplus4 got=%h exp=%h", PCPlus4, 32'h4); end
        tests_run++; if (Instr !== 32'h0) begin tests_failed++; $display("FAIL reset_instr got=%h exp=%h", Instr, 32'h0); end
        tests_run++; if (PC_d !== 32'h0) begin tests_failed++; $display("FAIL reset_pc_d got=%h exp=%h", PC_d, 32'h0); end
        tests_run++; if (valid_d !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got=%b exp=0", valid_d); end
        tests_run++; if (fetch_count !== 16'd0) begin tests_failed++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
    endtask

    task automatic test_load_and_fetch();
        logic [31:0] words [6];
        words[0] = 32'h1111_1111; words[1] = 32'h2222_2222;
        words[2] = 32'h3333_3333; words[3] = 32'h4444_4444;
        words[4] = INSTR_R5_R20;  words[5] = 32'h5555_5555;
        // Load while stalled so the PC and IF/ID stay at their reset values.
        stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            imem_we = 1'b1; imem_waddr = 6'(i); imem_wdata = words[i];
            tick();
        end
        imem_we = 1'b0;
        tests_run++; if (valid_d !== 1'b0) begin tests_failed++; $display("FAIL load_stalled_valid got=%b exp=0", valid_d); end
        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tests_run++; if (PC !== 32'(4 * i)) begin tests_failed++; $display("FAIL fetch_pc[%0d] got=%h exp=%h", i, PC, 32'(4 * i)); end
            tick();
            tests_run++; if (Instr !== words[i]) begin tests_failed++; $display("FAIL fetch_instr[%0d] got=%h exp=%h", i, Instr, words[i]); end
            tests_run++; if (PC_d !== 32'(4 * i)) begin tests_failed++; $display("FAIL fetch_pc_d[%0d] got=%h exp=%h", i, PC_d, 32'(4 * i)); end
            tests_run++; if (valid_d !== 1'b1) begin tests_failed++; $display("FAIL fetch_valid[%0d] got=%b exp=1", i, valid_d); end
        end
        tests_run++; if (PC !== 32'h10) begin tests_failed++; $display("FAIL fetch_pc_end got=%h exp=%h", PC, 32'h10); end
        tests_run++; if (fetch_count !== 16'd4) begin tests_failed++; $display("FAIL fetch_count got=%0d exp=4", fetch_count); end
    endtask

    task automatic test_branch();
        PCSrc = 1'b1; PCTarget = 32'h8;
        tick();
        PCSrc = 1'b0;
        tests_run++; if (PC !== 32'h8) begin tests_failed++; $display("FAIL branch_pc got=%h exp=%h", PC, 32'h8); end
        tests_run++; if (PCPlus4 !== 32'hC) begin tests_failed++; $display("FAIL branch_pcplus4 got=%h exp=%h", PCPlus4, 32'hC); end
        tick();
        tests_run++; if (Instr !== 32'h3333_3333) begin tests_failed++; $display("FAIL branch_instr got=%h exp=%h", Instr, 32'h3333_3333); end
        tests_run++; if (PC_d !== 32'h8) begin tests_failed++; $display("FAIL branch_pc_d got=%h exp=%h", PC_d, 32'h8); end
        tests_run++; if (fetch_count !== 16'd6) begin tests_failed++; $display("FAIL branch_count got=%0d exp=6", fetch_count); end
    endtask

    task automatic test_stall_flush();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++; if (PC !== 32'hC) begin tests_failed++; $display("FAIL stall_pc[%0d] got=%h exp=%h", i, PC, 32'hC); end
            tests_run++; if (Instr !== 32'h3333_3333) begin tests_failed++; $display("FAIL stall_instr[%0d] got=%h exp=%h", i, Instr, 32'h3333_3333); end
            tests_run++; if (PC_d !== 32'h8) begin tests_failed++; $display("FAIL stall_pc_d[%0d] got=%h exp=%h", i, PC_d, 32'h8); end
            tests_run++; if (fetch_count !== 16'd6) begin tests_failed++; $display("FAIL stall_count[%0d] got=%0d exp=6", i, fetch_count); end
        end
        // Redirect while stalled: PC moves, IF/ID holds.
        PCSrc = 1'b1; PCTarget = 32'h10;
        tick();
        PCSrc = 1'b0;
        tests_run++; if (PC !== 32'h10) begin tests_failed++; $display("FAIL stall_redirect_pc got=%h exp=%h", PC, 32'h10); end
        tests_run++; if (Instr !== 32'h3333_3333) begin tests_failed++; $display("FAIL stall_redirect_instr got=%h exp=%h", Instr, 32'h3333_3333); end
        // Flush together with stall: flush wins, PC still held.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tests_run++; if (Instr !== 32'h0) begin tests_failed++; $display("FAIL flush_instr got=%h exp=%h", Instr, 32'h0); end
        tests_run++; if (valid_d !== 1'b0) begin tests_failed++; $display("FAIL flush_valid got=%b exp=0", valid_d); end
        tests_run++; if (PC_d !== 32'h0) begin tests_failed++; $display("FAIL flush_pc_d got=%h exp=%h", PC_d, 32'h0); end
        tests_run++; if (PC !== 32'h10) begin tests_failed++; $display("FAIL flush_pc got=%h exp=%h", PC, 32'h10); end
        tests_run++; if (fetch_count !== 16'd6) begin tests_failed++; $display("FAIL flush_count got=%0d exp=6", fetch_count); end
    endtask

    task automatic test_regfile();
        stall = 1'b0;
        tick();                       // IF/ID <= word at 0x10 (rs=5, rt=20)
        stall = 1'b1;
        tests_run++; if (Instr !== INSTR_R5_R20) begin tests_failed++; $display("FAIL rf_instr got=%h exp=%h", Instr, INSTR_R5_R20); end
        tests_run++; if (SrcA !== 32'h0) begin tests_failed++; $display("FAIL rf_r5_init got=%h exp=%h", SrcA, 32'h0); end
        // Bypass of r5 in the same cycle.
        RegWrite = 1'b1; WriteReg = 5'd5; Result = 32'hDEAD_BEEF;
        #1;
        tests_run++; if (SrcA !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL rf_bypass got=%h exp=%h", SrcA, 32'hDEAD_BEEF); end
        tick();
        RegWrite = 1'b0;
        tests_run++; if (SrcA !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL rf_stored got=%h exp=%h", SrcA, 32'hDEAD_BEEF); end
        // r20 is out of range with NREGS=16: no bypass, no write.
        RegWrite = 1'b1; WriteReg = 5'd20; Result = 32'h1234_5678;
        #1;
        tests_run++; if (WriteData !== 32'h0) begin tests_failed++; $display("FAIL rf_r20_bypass got=%h exp=%h", WriteData, 32'h0); end
        tick();
        RegWrite = 1'b0;
        tests_run++; if (WriteData !== 32'h0) begin tests_failed++; $display("FAIL rf_r20_stored got=%h exp=%h", WriteData, 32'h0); end
        tests_run++; if (SrcA !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL rf_r5_kept got=%h exp=%h", SrcA, 32'hDEAD_BEEF); end
        // Flush gives Instr=0, so both fields select r0.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        RegWrite = 1'b1; WriteReg = 5'd0; Result = 32'hCAFE_BABE;
        #1;
        tests_run++; if (SrcA !== 32'h0) begin tests_failed++; $display("FAIL rf_r0_bypass got=%h exp=%h", SrcA, 32'h0); end
        tick();
        RegWrite = 1'b0;
        tests_run++; if (SrcA !== 32'h0) begin tests_failed++; $display("FAIL rf_r0_stored got=%h exp=%h", SrcA, 32'h0); end
        tests_run++; if (WriteData !== 32'h0) begin tests_failed++; $display("FAIL rf_r0_rt got=%h exp=%h", WriteData, 32'h0); end
    endtask

    task automatic test_out_of_range();
        stall = 1'b0;
        PCSrc = 1'b1; PCTarget = 32'(4 * IMEM_DEPTH);
        tick();                       // IF/ID <= word at 0x14
        PCSrc = 1'b0;
        tests_run++; if (Instr !== 32'h5555_5555) begin tests_failed++; $display("FAIL oor_prev_instr got=%h exp=%h", Instr, 32'h5555_5555); end
        tick();
        tests_run++; if (Instr !== 32'h0) begin tests_failed++; $display("FAIL oor_instr got=%h exp=%h", Instr, 32'h0); end
        tests_run++; if (PC_d !== 32'h100) begin tests_failed++; $display("FAIL oor_pc_d got=%h exp=%h", PC_d, 32'h100); end
        tests_run++; if (valid_d !== 1'b1) begin tests_failed++; $display("FAIL oor_valid got=%b exp=1", valid_d); end
        tests_run++; if (fetch_count !== 16'd9) begin tests_failed++; $display("FAIL oor_count got=%0d exp=9", fetch_count); end
        // PC+4 wraps modulo 2^32.
        PCSrc = 1'b1; PCTarget = 32'hFFFF_FFFC;
        tick();
        PCSrc = 1'b0;
        tests_run++; if (PCPlus4 !== 32'h0) begin tests_failed++; $display("FAIL wrap_pcplus4 got=%h exp=%h", PCPlus4, 32'h0); end
        tick();
        tests_run++; if (PC !== 32'h0) begin tests_failed++; $display("FAIL wrap_pc got=%h exp=%h", PC, 32'h0); end
        tests_run++; if (Instr !== 32'h0) begin tests_failed++; $display("FAIL wrap_instr got=%h exp=%h", Instr, 32'h0); end
    endtask

    task automatic test_imem_write_read();
        // PC=0: overwrite word 0 on the same edge that fetches it.
        imem_we = 1'b1; imem_waddr = 6'd0; imem_wdata = 32'hAAAA_AAAA;
        tick();
        imem_we = 1'b0;
        tests_run++; if (Instr !== 32'h1111_1111) begin tests_failed++; $display("FAIL imem_old got=%h exp=%h", Instr, 32'h1111_1111); end
        PCSrc = 1'b1; PCTarget = 32'h0;
        tick();
        PCSrc = 1'b0;
        tick();
        tests_run++; if (Instr !== 32'hAAAA_AAAA) begin tests_failed++; $display("FAIL imem_new got=%h exp=%h", Instr, 32'hAAAA_AAAA); end
    endtask

    task automatic test_mid_reset();
        rst = 1'b1; stall = 1'b1; flush = 1'b1; PCSrc = 1'b1; PCTarget = 32'h40;
        tick();
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        tests_run++; if (PC !== 32'h0) begin tests_failed++; $display("FAIL mrst_pc got=%h exp=%h", PC, 32'h0); end
        tests_run++; if (Instr !== 32'h0) begin tests_failed++; $display("FAIL mrst_instr got=%h exp=%h", Instr, 32'h0); end
        tests_run++; if (PC_d !== 32'h0) begin tests_failed++; $display("FAIL mrst_pc_d got=%h exp=%h", PC_d, 32'h0); end
        tests_run++; if (valid_d !== 1'b0) begin tests_failed++; $display("FAIL mrst_valid got=%b exp=0", valid_d); end
        tests_run++; if (fetch_count !== 16'd0) begin tests_failed++; $display("FAIL mrst_count got=%0d exp=0", fetch_count); end
        // Fetch the rs=5 word again: r5 must have been cleared by reset.
        PCTarget = 32'h10;
        tick();
        PCSrc = 1'b0;
        tick();
        tests_run++; if (Instr !== INSTR_R5_R20) begin tests_failed++; $display("FAIL mrst_instr2 got=%h exp=%h", Instr, INSTR_R5_R20); end
        tests_run++; if (SrcA !== 32'h0) begin tests_failed++; $display("FAIL mrst_r5 got=%h exp=%h", SrcA, 32'h0); end
        tests_run++; if (fetch_count !== 16'd2) begin tests_failed++; $display("FAIL mrst_count2 got=%0d exp=2", fetch_count); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_load_and_fetch();
        test_branch();
        test_stall_flush();
        test_regfile();
        test_out_of_range();
        test_imem_write_read();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fetch_regfile_stage.md
Name: fetch_regfile_stage

Overview:
- Parametrised successor of the single-cycle PC/fetch/register-file datapath.
- Holds the PC register and computes next-PC internally (PC+4 or branch target), fetches from a loadable instruction memory, and registers the fetched word in an IF/ID stage with valid, stall and flush.
- Provides two register-file read operands with write-through bypass from writeback.
- Sits between the control/writeback logic and the ALU of the first pipelined core.

Parameters:
- DATA_W, 32, register/instruction/PC width in bits.
- NREGS, 32, number of architectural registers (2..32); register 0 hardwired to zero.
- IMEM_DEPTH, 64, instruction memory depth in words (power of two).
- RESET_PC, 0, PC value loaded on reset (word aligned).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- PCSrc  in  1  1 = next PC is PCTarget.
- PCTarget  in  DATA_W  branch/jump target.
- stall  in  1  hold PC and IF/ID.
- flush  in  1  invalidate IF/ID on this edge.
- imem_we  in  1  instruction memory write enable (load port).
- imem_waddr  in  clog2(IMEM_DEPTH)  word address for load.
- imem_wdata  in  DATA_W  word to load.
- RegWrite  in  1  writeback enable.
- WriteReg  in  5  writeback destination register.
- Result  in  DATA_W  writeback data.
- PC  out  DATA_W  current fetch PC.
- PCPlus4  out  DATA_W  PC+4 (combinational).
- Instr  out  DATA_W  IF/ID instruction.
- PC_d  out  DATA_W  IF/ID PC.
- valid_d  out  1  IF/ID valid.
- SrcA  out  DATA_W  value of reg Instr[25:21].
- WriteData  out  DATA_W  value of reg Instr[20:16].
- fetch_count  out  16  count of valid words captured into IF/ID.

Behaviour:
- Reset, synchronous:
  - PC=RESET_PC; Instr=0; PC_d=0; valid_d=0; fetch_count=0.
  - All registers cleared to 0.
  - Instruction memory is NOT cleared.
  - Reset overrides every other input on that edge.
- Next PC at each edge:
  - PCSrc=1: PC<=PCTarget. Redirect takes priority over stall.
  - PCSrc=0 and stall=0: PC<=PC+4, modulo 2^DATA_W.
  - PCSrc=0 and stall=1: PC holds.
- Fetch, combinational:
  - Word index = PC[2+:clog2(IMEM_DEPTH)].
  - If PC >= 4*IMEM_DEPTH, fetched word is 0 (NOP). No wrap.
  - PC[1:0] is ignored.
- IF/ID update, priority flush > stall > load:
  - flush=1: Instr<=0, PC_d<=0, valid_d<=0.
  - stall=1: all IF/ID outputs hold.
  - Otherwise: Instr<=fetched word, PC_d<=PC, valid_d<=1.
- Latency: a word at address A appears on Instr one edge after PC==A, provided that edge is not stalled or flushed.
- fetch_count:
  - Increments on each edge where the IF/ID load path is taken (valid_d becomes 1 from a fresh fetch).
  - Saturates at 16'hFFFF.
- Instruction memory load:
  - Write occurs at the edge when imem_we=1.
  - A fetch of the same word in that cycle returns the old contents.
- Register file reads, combinational:
  - Read address = instruction field.
  - Field == 0 or field >= NREGS reads 0.
  - Bypass: if RegWrite=1, WriteReg==field, and field is nonzero and < NREGS, output Result instead of the stored value.
- Register file write:
  - At the edge when RegWrite=1 and WriteReg is in 1..NREGS-1.
  - Writes to 0 or out-of-range registers are ignored.
- Simultaneous events:
  - stall and flush together: flush wins.
  - PCSrc and stall together: PC redirects and IF/ID holds.
  - A write and a bypass read in the same cycle are consistent by construction.
- Reset mid-stall or mid-flush: reset values take effect regardless.

Test Plan:
- Reset, then load imem words 0..3 = 11111111, 22222222, 33333333, 44444444, then run 4 clocks with no stall -> PC goes 0,4,8,C,10; Instr follows one cycle later = 11111111..44444444; valid_d=1; fetch_count=4.
- PCSrc=1, PCTarget=0x8 for one cycle -> PC=8 next edge; the next Instr is 33333333; PCPlus4=0xC.
- Hold stall=1 for 3 cycles -> PC, Instr, PC_d and fetch_count frozen; asserting flush with stall gives Instr=0 and valid_d=0.
- Instr rs=5: RegWrite=1, WriteReg=5, Result=DEADBEEF -> SrcA=DEADBEEF in the same cycle (bypass); after the edge with RegWrite=0, SrcA=DEADBEEF from storage.
- RegWrite=1, WriteReg=0, Result=CAFEBABE -> a read of r0 stays 0; with NREGS=16, a write to r20 is ignored and a read of r20 returns 0.
- PCTarget=4*IMEM_DEPTH -> fetched word 0; assert rst mid-run -> all outputs return to reset values on the next edge.
